// File: rtl/pipe_ex_pkg.sv
// pipe_ex_pkg
// Shared definitions for the pipe_ex controller slice: default datapath
// width, latency and result FIFO depth, the result-word type, and the
// helper that sizes FIFO pointers and occupancy counters from a depth.
// No ports (package).
package pipe_ex_pkg;

    localparam int PIPE_EX_N     = 10;
    localparam int PIPE_EX_LAT   = 4;
    localparam int PIPE_EX_DEPTH = 8;

    // Pointer width for the default depth; counters need one extra bit so
    // that a completely full FIFO (count == DEPTH) is representable.
    localparam int PIPE_EX_PTR_W = $clog2(PIPE_EX_DEPTH);
    localparam int PIPE_EX_CNT_W = PIPE_EX_PTR_W + 1;

    typedef logic [PIPE_EX_N-1:0] res_word_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pipe_ex_res_fifo.sv
// pipe_ex_res_fifo
// Synchronous DEPTH x N result FIFO with push/pop and an occupancy count.
// Full/empty come from the count, so pointers simply wrap at DEPTH.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   push, push_data   write one word at the tail
//   pop               drop the head word
//   head_data         current head word (valid while !empty)
//   count             number of stored words, 0..DEPTH
//   empty             count == 0
module pipe_ex_res_fifo
    import pipe_ex_pkg::*;
#(
    parameter  int N     = PIPE_EX_N,
    parameter  int DEPTH = PIPE_EX_DEPTH,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [N-1:0]     push_data,
    input  logic             pop,
    output logic [N-1:0]     head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [N-1:0]     mem_q [DEPTH];
    logic [N-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));

    // Next-state: push and pop are independent and may coincide; the count
    // moves by the net delta.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The credit scheme upstream must make these impossible.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/pipe_ex_ctrl.sv
// pipe_ex_ctrl
// Flow-controlled front/back end for the fixed-latency, non-stallable
// arithmetic datapath f = ((a+b)+(c-d))*d mod 2^N.  Operand sets are taken
// on a valid/ready port and registered onto dp_*; a valid shift register
// follows each issue through the datapath latency and pushes dp_f into a
// result FIFO drained by a valid/ready output port.  An issue is only
// allowed while (buffered + in-flight) < DEPTH, so every result that comes
// out of the datapath is guaranteed a FIFO slot.
// Optional macro PIPE_EX_CHECK_EN adds a shadow model of the datapath and a
// sticky err output that flags any dp_f that disagrees with it.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake, in_a..in_d operands
//   dp_a..dp_d               registered operands to the datapath
//   dp_f                     datapath result
//   out_valid/out_ready      result handshake, out_f = FIFO head
//   err                      sticky checker flag (PIPE_EX_CHECK_EN only)
module pipe_ex_ctrl
    import pipe_ex_pkg::*;
#(
    parameter int N     = PIPE_EX_N,
    parameter int LAT   = PIPE_EX_LAT,
    parameter int DEPTH = PIPE_EX_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_c,
    input  logic [N-1:0] in_d,
    output logic [N-1:0] dp_a,
    output logic [N-1:0] dp_b,
    output logic [N-1:0] dp_c,
    output logic [N-1:0] dp_d,
    input  logic [N-1:0] dp_f,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_f
`ifdef PIPE_EX_CHECK_EN
    ,
    output logic         err
`endif
);

    localparam int CNT_W = ptr_width(DEPTH) + 1;

    logic             issue;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;

    logic [LAT:0]     track_q, track_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [N-1:0]     dp_a_q, dp_a_d;
    logic [N-1:0]     dp_b_q, dp_b_d;
    logic [N-1:0]     dp_c_q, dp_c_d;
    logic [N-1:0]     dp_d_q, dp_d_d;

    // Credit check uses only registered counters, so a pop frees its slot
    // one cycle later and out_ready never reaches in_ready combinationally.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign in_ready  = !rst && (occupancy < (CNT_W+1)'(DEPTH));
    assign issue     = in_valid && in_ready;

    // Bit LAT is set during the cycle in which dp_f holds this issue's
    // result, so the FIFO samples it on the following edge.
    assign fifo_push = track_q[LAT];
    assign fifo_pop  = out_valid && out_ready;
    assign out_valid = !fifo_empty;

    assign dp_a = dp_a_q;
    assign dp_b = dp_b_q;
    assign dp_c = dp_c_q;
    assign dp_d = dp_d_q;

    // Issue tracking and operand registers.
    always_comb begin
        track_d    = {track_q[LAT-1:0], issue};
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(fifo_push);
        dp_a_d     = dp_a_q;
        dp_b_d     = dp_b_q;
        dp_c_d     = dp_c_q;
        dp_d_d     = dp_d_q;
        if (issue) begin
            dp_a_d = in_a;
            dp_b_d = in_b;
            dp_c_d = in_c;
            dp_d_d = in_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            track_q    <= '0;
            inflight_q <= '0;
            dp_a_q     <= '0;
            dp_b_q     <= '0;
            dp_c_q     <= '0;
            dp_d_q     <= '0;
        end else begin
            track_q    <= track_d;
            inflight_q <= inflight_d;
            dp_a_q     <= dp_a_d;
            dp_b_q     <= dp_b_d;
            dp_c_q     <= dp_c_d;
            dp_d_q     <= dp_d_d;
        end
    end

    pipe_ex_res_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (dp_f),
        .pop       (fifo_pop),
        .head_data (out_f),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

`ifdef PIPE_EX_CHECK_EN
    logic [N-1:0] shadow_f;
    logic [N-1:0] exp_q [LAT+1];
    logic [N-1:0] exp_d [LAT+1];
    logic         err_q, err_d;

    // The expected result is computed from the operands at issue time and
    // delayed alongside the tracking bit; slot LAT lines up with fifo_push.
    always_comb begin
        shadow_f = (in_a + in_b + (in_c - in_d)) * in_d;
        exp_d[0] = shadow_f;
        for (int i = 1; i <= LAT; i++) begin
            exp_d[i] = exp_q[i-1];
        end
        err_d = err_q | (fifo_push && (dp_f != exp_q[LAT]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= LAT; i++) begin
                exp_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_pipe_ex_ctrl.sv
// tb_pipe_ex_ctrl
// Bench for pipe_ex_ctrl.  Provides a behavioural 4-stage datapath on
// dp_f, a queue-based model of the controller's external behaviour, a
// per-cycle compare process and directed scenarios with literal checks.
// Define PIPE_EX_CHECK_EN to also exercise the err output.
module tb_pipe_ex_ctrl;
    import pipe_ex_pkg::*;

    localparam int N     = PIPE_EX_N;
    localparam int LAT   = PIPE_EX_LAT;
    localparam int DEPTH = PIPE_EX_DEPTH;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a, in_b, in_c, in_d;
    logic [N-1:0] dp_a, dp_b, dp_c, dp_d;
    logic [N-1:0] dp_f;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_f;
`ifdef PIPE_EX_CHECK_EN
    logic         err;
`endif

    logic         corrupt;
    res_word_t    dp_stage [LAT];

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    pipe_ex_ctrl #(
        .N     (N),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_c      (dp_c),
        .dp_d      (dp_d),
        .dp_f      (dp_f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f)
`ifdef PIPE_EX_CHECK_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain-integer statement of f = ((a+b)+(c-d))*d mod 1024.
    function automatic int modelF(input int a, input int b, input int c, input int d);
        int x;
        x = (a + b + c + 1024 - d) % 1024;
        return (x * d) % 1024;
    endfunction

    // Datapath stand-in: result appears LAT edges after dp_* change.
    always @(posedge clk) begin
        dp_stage[0] <= N'(modelF(int'(dp_a), int'(dp_b), int'(dp_c), int'(dp_d)));
        for (int i = 1; i < LAT; i++) begin
            dp_stage[i] <= dp_stage[i-1];
        end
    end
    assign dp_f = dp_stage[LAT-1] ^ {{(N-1){1'b0}}, corrupt};

    // Model: every accepted operand set is one queue entry stamped with its
    // issue edge; it becomes visible LAT+1 edges later and leaves on a pop.
    typedef struct {
        int f;
        int t;
    } item_t;

    item_t model_q[$];
    bit    exp_err = 1'b0;
    int    exp_dp[4] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        bit pre_valid;
        bit pre_ready;
        pre_valid = (model_q.size() > 0) && (model_q[0].t + LAT + 1 <= cyc);
        pre_ready = (model_q.size() < DEPTH);
        if (rst) begin
            model_q.delete();
            exp_err = 1'b0;
            exp_dp  = '{0, 0, 0, 0};
        end else begin
            foreach (model_q[i]) begin
                if (model_q[i].t + LAT == cyc && corrupt) begin
                    model_q[i].f = model_q[i].f ^ 1;
                    exp_err      = 1'b1;
                end
            end
            if (pre_valid && out_ready) begin
                void'(model_q.pop_front());
            end
            if (in_valid && pre_ready) begin
                model_q.push_back('{modelF(int'(in_a), int'(in_b), int'(in_c), int'(in_d)), cyc + 1});
                exp_dp = '{int'(in_a), int'(in_b), int'(in_c), int'(in_d)};
            end
        end
        cyc++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        bit exp_valid;
        #1;
        exp_valid = (model_q.size() > 0) && (model_q[0].t + LAT + 1 <= cyc);
        checkOutput("in_ready", int'(in_ready), int'(!rst && model_q.size() < DEPTH));
        checkOutput("out_valid", int'(out_valid), int'(exp_valid));
        if (exp_valid) begin
            checkOutput("out_f", int'(out_f), model_q[0].f);
        end
        checkOutput("dp_a", int'(dp_a), exp_dp[0]);
        checkOutput("dp_b", int'(dp_b), exp_dp[1]);
        checkOutput("dp_c", int'(dp_c), exp_dp[2]);
        checkOutput("dp_d", int'(dp_d), exp_dp[3]);
`ifdef PIPE_EX_CHECK_EN
        checkOutput("err", int'(err), int'(exp_err));
`endif
    end

    // Event counters for the directed scenarios.
    int pop_cnt   = 0;
    int first_pop = 0;
    int last_pop  = 0;
    int valid_cnt = 0;
    int stall_cnt = 0;

    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) begin
            pop_cnt++;
            if (pop_cnt == 1) first_pop = cyc;
            last_pop = cyc;
        end
        if (out_valid) valid_cnt++;
        if (in_valid && !in_ready) stall_cnt++;
    end

    task automatic clearCounters();
        pop_cnt   = 0;
        first_pop = 0;
        last_pop  = 0;
        valid_cnt = 0;
        stall_cnt = 0;
    endtask

    // Presents one operand set for one cycle; e0 is the issue edge number.
    task automatic applyStimulus(input int a, input int b, input int c, input int d, output int e0);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = N'(a);
        in_b     = N'(b);
        in_c     = N'(c);
        in_d     = N'(d);
        checkOutput("issue_ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        e0       = cyc;
    endtask

    task automatic waitResult(input int e0, output int lat, output int f);
        for (int k = 0; k < 30 && !out_valid; k++) @(negedge clk);
        if (!out_valid) checkOutput("result_timeout", 0, 1);
        lat = cyc - e0;
        f   = int'(out_f);
    endtask

    initial begin
        int e0, lat, f, acc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        in_d      = '0;
        out_ready = 1'b1;
        corrupt   = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", int'(in_ready), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic");
        applyStimulus(3, 5, 9, 2, e0);
        waitResult(e0, lat, f);
        checkOutput("basic_latency", lat, 5);
        checkOutput("basic_f", f, 30);
        repeat (3) @(negedge clk);

        $display("[TB] wrap-around");
        applyStimulus(1000, 100, 0, 3, e0);
        waitResult(e0, lat, f);
        checkOutput("wrap_f", f, 219);
        repeat (3) @(negedge clk);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        clearCounters();
        acc = 0;
        for (int i = 0; i < 28; i++) begin
            in_valid = 1'b1;
            in_a     = N'(acc * 37 + 1);
            in_b     = N'(acc * 11);
            in_c     = N'(acc * 5 + 2);
            in_d     = N'(acc + 1);
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("bp_accepted", acc, 8);
        checkOutput("bp_stalled_cycles", stall_cnt, 20);
        clearCounters();
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("bp_drained", pop_cnt, 8);

        $display("[TB] streaming");
        clearCounters();
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_a     = N'(i * 13);
            in_b     = N'(i * 7 + 1);
            in_c     = N'(i * 3);
            in_d     = N'(i % 17 + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("stream_results", pop_cnt, 100);
        checkOutput("stream_span", last_pop - first_pop, 99);
        checkOutput("stream_stalls", stall_cnt, 0);

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = N'(i + 20);
            in_b     = N'(i + 40);
            in_c     = N'(i + 60);
            in_d     = N'(i + 5);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clearCounters();
        repeat (15) @(negedge clk);
        checkOutput("rst_no_stale", valid_cnt, 0);
        applyStimulus(1, 1, 1, 1, e0);
        waitResult(e0, lat, f);
        checkOutput("rst_next_latency", lat, 5);
        checkOutput("rst_next_f", f, 2);
        repeat (3) @(negedge clk);

`ifdef PIPE_EX_CHECK_EN
        $display("[TB] checker");
        checkOutput("chk_err_clean", int'(err), 0);
        applyStimulus(3, 5, 9, 2, e0);
        repeat (4) @(negedge clk);
        corrupt = 1'b1;
        @(negedge clk);
        corrupt = 1'b0;
        checkOutput("chk_valid", int'(out_valid), 1);
        checkOutput("chk_out_f", int'(out_f), 31);
        checkOutput("chk_err_set", int'(err), 1);
        repeat (6) @(negedge clk);
        checkOutput("chk_err_sticky", int'(err), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("chk_err_cleared", int'(err), 0);
        repeat (2) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
